// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply-divide unit producing HI/LO
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiply for MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               op_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz_q;

    logic               op_valid;
    logic               op_is_div;
    logic               op_signed;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // opcodes 12..15: bit1 selects divide, bit0 selects unsigned
    assign op_valid  = (alu_op[4:2] == 3'b011);
    assign op_is_div = alu_op[1];
    assign op_signed = ~alu_op[0];
    assign s1        = op_signed & src1[WIDTH-1];
    assign s2        = op_signed & src2[WIDTH-1];
    assign abs1      = s1 ? -src1 : src1;
    assign abs2      = s2 ? -src2 : src2;

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo ? -acc : acc;

    // With a zero divisor every trial succeeds, so the remainder ends up holding
    // |src1|; re-applying the dividend sign restores the original src1 in hi.
    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (op_div) begin
            fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            if (dz_q)
                fix_lo = {WIDTH{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz_q        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && op_valid && !cancel) begin
                        op_div <= op_is_div;
                        dz_q   <= op_is_div && (src2 == '0);
                        neg_lo <= s1 ^ s2;
                        neg_hi <= s1;
                        cnt    <= '0;
                        if (op_is_div) begin
                            opnd  <= abs2;
                            acc   <= {{WIDTH{1'b0}}, abs1};
                            state <= S_CALC;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc   <= {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
                            state <= S_FIX;
`else
                            opnd  <= abs1;
                            acc   <= {{WIDTH{1'b0}}, abs2};
                            state <= S_CALC;
`endif
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= op_div ? div_next : mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        hi          <= fix_hi;
                        lo          <= fix_lo;
                        div_by_zero <= dz_q;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   alu_op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int lat;
    int ndone;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .src1(src1), .src2(src2), .cancel(cancel), .busy(busy),
        .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned between edges in an IDLE cycle; returns just after E0.
    task automatic launch(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; alu_op = op; src1 = a; src2 = b;
        @(posedge clk);
        #1 start = 1'b0; alu_op = 5'd0;
    endtask

    task automatic wait_done(output int n_out);
        n_out = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic finish_op(input string tag, input int exp_lat);
        int l;
        wait_done(l);
        check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; alu_op = '0; src1 = '0; src2 = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        check("multu_lat", 64'(lat), 64'(MUL_LAT));
        check("multu_hi", 64'(hi), 64'hFFFFFFFE);
        check("multu_lo", 64'(lo), 64'h00000001);
        @(negedge clk);
        check("multu_done_pulse", 64'(done), 64'd0);
        check("multu_busy_after", 64'(busy), 64'd0);

        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        finish_op("mult", MUL_LAT);
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFEB);
        @(negedge clk);

        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        finish_op("div", DIV_LAT);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_hi", 64'(hi), 64'hFFFFFFFF);
        check("div_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);

        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        finish_op("ovf", DIV_LAT);
        check("ovf_lo", 64'(lo), 64'h80000000);
        check("ovf_hi", 64'(hi), 64'd0);
        check("ovf_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);

        launch(OP_DIVU, 32'd100, 32'd0);
        finish_op("dz", DIV_LAT);
        check("dz_lo", 64'(lo), 64'hFFFFFFFF);
        check("dz_hi", 64'(hi), 64'd100);
        check("dz_flag", 64'(div_by_zero), 64'd1);
        @(negedge clk);

        // Signed divide by zero returns the original negative dividend in hi
        launch(OP_DIV, 32'hFFFFFF00, 32'd0);
        finish_op("sdz", DIV_LAT);
        check("sdz_lo", 64'(lo), 64'hFFFFFFFF);
        check("sdz_hi", 64'(hi), 64'hFFFFFF00);
        @(negedge clk);

        // Second start while busy must be dropped
        launch(OP_DIVU, 32'd50, 32'd7);
        repeat (4) @(negedge clk);
        launch(OP_MULTU, 32'd3, 32'd3);
        ndone = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("busy_start_ndone", 64'(ndone), 64'd1);
        check("busy_start_lo", 64'(lo), 64'd7);
        check("busy_start_hi", 64'(hi), 64'd1);
        check("busy_start_idle", 64'(busy), 64'd0);

        // cancel and start together in IDLE launches nothing
        cancel = 1'b1;
        launch(OP_DIVU, 32'd9, 32'd3);
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_start_busy", 64'(busy), 64'd0);

        // cancel sampled at E10
        launch(OP_DIVU, 32'd1000, 32'd10);
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel_ndone", 64'(ndone), 64'd0);
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_hi_keep", 64'(hi), 64'd1);
        check("cancel_lo_keep", 64'(lo), 64'd7);
        launch(OP_DIVU, 32'd1000, 32'd10);
        finish_op("post_cancel", DIV_LAT);
        check("post_cancel_lo", 64'(lo), 64'd100);
        check("post_cancel_hi", 64'(hi), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of CALC
        launch(OP_DIVU, 32'h12345678, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        launch(OP_DIV, 32'hFFFFFF9C, 32'd7);
        finish_op("post_rst", DIV_LAT);
        check("post_rst_lo", 64'(lo), 64'hFFFFFFF2);
        check("post_rst_hi", 64'(hi), 64'hFFFFFFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage. It implements the four ALU opcodes reserved for multiply and divide (12–15) that the combinational ALU path does not execute. Signed and unsigned operands are supported at a parametrised width, and the unit writes a HI/LO result pair. The ID stage holds the pipeline on `busy`; `done` marks the cycle in which HI/LO become valid.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  Clock. All state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low. The unit is in reset while `rst`=0.
- `start`  in  1  Launch request; sampled only in IDLE.
- `alu_op`  in  5  Operation code: 12=MULT, 13=MULTU, 14=DIV, 15=DIVU. Any other value is ignored.
- `src1`  in  WIDTH  Multiplicand / dividend.
- `src2`  in  WIDTH  Multiplier / divisor.
- `cancel`  in  1  Synchronous flush (exception or branch squash).
- `busy`  out  1  High whenever the state is not IDLE.
- `done`  out  1  One-cycle pulse; `hi`/`lo` are valid from this cycle onward.
- `hi`  out  WIDTH  High product half, or remainder.
- `lo`  out  WIDTH  Low product half, or quotient.
- `div_by_zero`  out  1  Valid with `done`; set for DIV/DIVU with `src2`=0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC when `start`=1, `alu_op` ∈ {12..15} and `cancel`=0.
  - On this transition the operands are latched as absolute values, with `WIDTH`-bit sign handling for MULT/DIV.
  - The result signs are recorded: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
- CALC lasts exactly `WIDTH` cycles and is counted by a `CNT_W`-bit counter.
  - Multiply: radix-2 shift-add into a 2·`WIDTH` accumulator.
  - Divide: radix-2 restoring division, producing a `WIDTH`-bit quotient and remainder.
- FIX lasts one cycle. It applies two's-complement negation per the recorded signs and loads `hi`/`lo`.
- DONE lasts one cycle. It asserts `done` and sets `div_by_zero`, then returns to IDLE.
- Arithmetic rules:
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case: −2^(WIDTH−1) / −1 gives `lo`=−2^(WIDTH−1) and `hi`=0.
- Divide by zero:
  - Takes the normal latency.
  - Result: `lo`=all ones, `hi`=`src1` (unmodified original value), `div_by_zero`=1.
- `hi`/`lo` hold their value until the next FIX. `div_by_zero` holds until the next DONE.
- `start` while `busy`=1 is ignored and is not queued.
- `cancel`=1 in any non-IDLE state:
  - Next state is IDLE.
  - No `done` pulse is produced.
  - `hi`, `lo` and `div_by_zero` keep their previous values.
- `cancel` and `start` in the same IDLE cycle: `cancel` wins and nothing is launched.
- `cancel` in the DONE cycle: `done` still pulses, because the results were already written in FIX.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0.
  - Outputs clear immediately on `rst`=0, independent of `clk`.
  - Asserting reset mid-operation discards the operation.
- Let edge E0 be the edge that samples `start`. Then:
  - `busy`=1 from E0 until the edge after DONE.
  - FIX occupies the cycle after edge E`WIDTH`.
  - `done`=1 in the cycle after edge E(`WIDTH`+1).
  - Total latency is `WIDTH`+2 cycles, i.e. 34 at `WIDTH`=32.
- A new `start` is accepted in the first IDLE cycle after DONE, giving a back-to-back issue interval of `WIDTH`+3 cycles.
- `busy` is a registered output; the ID-stage stall logic combines it with `start`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `WIDTH`×`WIDTH` array multiply.
  - IDLE → FIX directly, so `done` is asserted 2 cycles after E0.
  - DIV/DIVU are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all four operations use the iterative CALC path with latency `WIDTH`+2.
- Results are bit-identical in both configurations.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` is asserted 34 cycles after E0, or 2 cycles with `MULDIV_FAST_MUL_EN`.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
  - Follow with DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=100, `div_by_zero`=1.
- `start` again while `busy`: the second request is ignored and exactly one `done` is seen.
- `cancel` 10 cycles after E0 → no `done`, `hi`/`lo` keep prior values, `busy`=0 next cycle.
  - A new `start` in that IDLE cycle completes normally.
- `rst`=0 mid-CALC, asynchronously between edges → all outputs are 0 immediately.
  - After release, an operation issued normally completes with the correct result.
